mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 70 +++++++
 rtl/mem_access_load_ext.sv | 34 +++
 rtl/mem_access.sv | 195 +++++++++++++++++++
 tb/tb_mem_access.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the M-stage memory access path: op encodings,
// exception codes, FSM state encoding and small decode helpers.
package mem_access_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Codes 9..15 behave exactly like OP_NONE.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= OP_LW) && (op <= OP_SB);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic is_aligned(input logic [3:0] op, input logic [1:0] lo);
    logic ok;
    ok = 1'b1;
    case (op)
      OP_LW, OP_SW:         ok = (lo == 2'b00);
      OP_LH, OP_LHU, OP_SH: ok = (lo[0] == 1'b0);
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] lo);
    logic [3:0] be;
    case (op)
      OP_SW:   be = 4'b1111;
      OP_SH:   be = 4'b0011 << lo;
      OP_SB:   be = 4'b0001 << lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate narrow store data across all lanes so the byte enables alone
  // pick the target lane.
  function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] w;
    case (op)
      OP_SH:   w = {2{d[15:0]}};
      OP_SB:   w = {4{d[7:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Load lane selection and sign/zero extension of a captured bus word.
module load_ext
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  // Little-endian lane pick, then extension chosen by the load flavour.
  always_comb begin
    half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    byte_v = 8'h00;
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (op)
      OP_LW:   data = rdata;
      OP_LH:   data = {{16{half[15]}}, half};
      OP_LHU:  data = {16'h0000, half};
      OP_LB:   data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  data = {24'h000000, byte_v};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// M-stage memory access controller: issues one bus transaction per load or
// store, stalls the pipe until it completes, and merges address/bus errors
// into the exception code.
//
// state | meaning
// IDLE  | no transaction; decode the M instruction, start or fault it
// REQ   | bus_req held high, waiting for bus_ack or timeout
// DONE  | one cycle presenting the extended result and registered exception
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic [31:0] ALU_OUT_M,
  input  logic [31:0] WRITE_DATA_M,
  input  logic [3:0]  MEM_OP_M,
  input  logic [4:0]  EXP_M,
  output logic [31:0] Real_MEM_OUT_M,
  output logic [4:0]  EXP_OUT_M,
  output logic        STALL_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  exc_q, exc_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        candidate;
  logic        access;
  logic        misaligned;
  logic [31:0] ext_data;

  load_ext u_load_ext (
    .op      (op_q),
    .addr_lo (lo_q),
    .rdata   (rdata_q),
    .data    (ext_data)
  );

  // Decode the M instruction; reset gating keeps STALL_M low while held in reset.
  always_comb begin
    candidate  = (state_q == ST_IDLE) && is_mem_op(MEM_OP_M) &&
                 (EXP_M == EXC_NONE) && !clr;
    access     = reset && candidate && is_aligned(MEM_OP_M, ALU_OUT_M[1:0]);
    misaligned = candidate && !is_aligned(MEM_OP_M, ALU_OUT_M[1:0]);
  end

  // Next-state, timeout counter, kill flag and bus register updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    op_d        = op_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    exc_d       = exc_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          state_d     = ST_REQ;
          cnt_d       = 8'd0;
          kill_d      = 1'b0;
          op_d        = MEM_OP_M;
          lo_d        = ALU_OUT_M[1:0];
          rdata_d     = 32'h0000_0000;
          exc_d       = EXC_NONE;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store(MEM_OP_M);
          bus_addr_d  = ALU_OUT_M[31:2];
          bus_be_d    = store_be(MEM_OP_M, ALU_OUT_M[1:0]);
          bus_wdata_d = store_wdata(MEM_OP_M, WRITE_DATA_M);
        end
      end
      ST_REQ: begin
        if (bus_ack || (cnt_q == CNT_LAST)) begin
          // A flush seen in the completing cycle discards the result too.
          cnt_d     = 8'd0;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_be_d  = 4'b0000;
          rdata_d   = bus_ack ? bus_rdata : 32'h0000_0000;
          if (kill_q || clr) begin
            state_d = ST_IDLE;
            kill_d  = 1'b0;
          end else begin
            state_d = ST_DONE;
            exc_d   = bus_ack ? EXC_NONE : EXC_DBE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (clr) begin
            kill_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      kill_q      <= 1'b0;
      op_q        <= OP_NONE;
      lo_q        <= 2'b00;
      rdata_q     <= 32'h0000_0000;
      exc_q       <= EXC_NONE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 30'h0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      exc_q       <= exc_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Pipeline-facing outputs: stall, result and merged exception.
  always_comb begin
    STALL_M        = reset && (access || (state_q == ST_REQ));
    Real_MEM_OUT_M = 32'h0000_0000;
    EXP_OUT_M      = EXC_NONE;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          EXP_OUT_M = EXC_NONE;
        end else if (misaligned) begin
          EXP_OUT_M = is_store(MEM_OP_M) ? EXC_ADES : EXC_ADEL;
        end else begin
          EXP_OUT_M = EXP_M;
        end
      end
      ST_DONE: begin
        if (!clr) begin
          Real_MEM_OUT_M = ext_data;
          EXP_OUT_M      = exc_q;
        end
      end
      default: begin
        EXP_OUT_M = EXC_NONE;
      end
    endcase
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: one instance with a long timeout for the
// normal access paths, one with TIMEOUT=4 for the bus-error path.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset, clr;
  logic [31:0] alu, wd, rdata;
  logic [3:0]  op, to_op;
  logic [4:0]  expm;
  logic        ack, to_ack;

  logic [31:0] real_out, to_real;
  logic [4:0]  exp_out, to_exp;
  logic        stall, to_stall;
  logic        b_req, b_we, to_req, to_we;
  logic [29:0] b_addr, to_addr;
  logic [3:0]  b_be, to_be;
  logic [31:0] b_wd, to_wd;

  int n_tot = 0;
  int n_bad = 0;

  int          st_n, rq_n;
  logic [3:0]  s_be;
  logic        s_we;
  logic [31:0] s_addr, s_wd, s_res;
  logic [4:0]  s_exc;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(8)) u_dut (
    .clk(clk), .reset(reset), .clr(clr),
    .ALU_OUT_M(alu), .WRITE_DATA_M(wd), .MEM_OP_M(op), .EXP_M(expm),
    .Real_MEM_OUT_M(real_out), .EXP_OUT_M(exp_out), .STALL_M(stall),
    .bus_req(b_req), .bus_we(b_we), .bus_addr(b_addr), .bus_be(b_be),
    .bus_wdata(b_wd), .bus_rdata(rdata), .bus_ack(ack)
  );

  mem_access #(.TIMEOUT(4)) u_to (
    .clk(clk), .reset(reset), .clr(clr),
    .ALU_OUT_M(alu), .WRITE_DATA_M(wd), .MEM_OP_M(to_op), .EXP_M(expm),
    .Real_MEM_OUT_M(to_real), .EXP_OUT_M(to_exp), .STALL_M(to_stall),
    .bus_req(to_req), .bus_we(to_we), .bus_addr(to_addr), .bus_be(to_be),
    .bus_wdata(to_wd), .bus_rdata(rdata), .bus_ack(to_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access on u_dut: IDLE cycle, dly cycles without ack, ack cycle, DONE.
  task automatic acc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] r, input int dly);
    st_n = 0;
    rq_n = 0;
    @(negedge clk);
    op = o; alu = a; wd = d; ack = 1'b0; clr = 1'b0;
    #1;
    st_n = st_n + int'(stall);
    rq_n = rq_n + int'(b_req);
    for (int c = 0; c <= dly; c++) begin
      @(negedge clk);
      ack   = (c == dly);
      rdata = (c == dly) ? r : 32'hA5A5_A5A5;
      #1;
      st_n = st_n + int'(stall);
      rq_n = rq_n + int'(b_req);
      if (c == 0) begin
        s_be = b_be; s_we = b_we; s_addr = 32'(b_addr); s_wd = b_wd;
      end
    end
    @(negedge clk);
    ack = 1'b0; rdata = 32'h0;
    #1;
    st_n  = st_n + int'(stall);
    rq_n  = rq_n + int'(b_req);
    s_res = real_out;
    s_exc = exp_out;
    @(negedge clk);
    op = 4'd0; alu = 32'h0; wd = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_seen;
    reset = 1'b0; clr = 1'b0; alu = 32'h0; wd = 32'h0; rdata = 32'h0;
    op = 4'd0; to_op = 4'd0; expm = 5'd0; ack = 1'b0; to_ack = 1'b0;
    #1;
    chk("rst_bus_req", 32'(b_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_be", 32'(b_be), 32'd0);
    chk("rst_bus_addr", 32'(b_addr), 32'd0);
    chk("rst_bus_wdata", b_wd, 32'd0);
    chk("rst_real", real_out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // LW, ack in the first REQ cycle
    acc(4'd1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
    chk("lw_stall_cycles", 32'(st_n), 32'd2);
    chk("lw_req_cycles", 32'(rq_n), 32'd1);
    chk("lw_be", 32'(s_be), 32'hF);
    chk("lw_we", 32'(s_we), 32'd0);
    chk("lw_addr", s_addr, 32'h40);
    chk("lw_result", s_res, 32'hDEAD_BEEF);
    chk("lw_exc", 32'(s_exc), 32'd0);

    // Sub-word loads
    acc(4'd4, 32'h0000_0103, 32'h0, 32'h8012_3456, 2);
    chk("lb_stall_cycles", 32'(st_n), 32'd4);
    chk("lb_req_cycles", 32'(rq_n), 32'd3);
    chk("lb_result", s_res, 32'hFFFF_FF80);
    acc(4'd5, 32'h0000_0103, 32'h0, 32'h8012_3456, 0);
    chk("lbu_result", s_res, 32'h0000_0080);
    acc(4'd2, 32'h0000_0102, 32'h0, 32'h8012_3456, 1);
    chk("lh_result", s_res, 32'hFFFF_8012);
    acc(4'd3, 32'h0000_0100, 32'h0, 32'h8012_8456, 0);
    chk("lhu_result", s_res, 32'h0000_8456);

    // Stores
    acc(4'd7, 32'h0000_0202, 32'h0000_ABCD, 32'hFFFF_FFFF, 0);
    chk("sh_be", 32'(s_be), 32'hC);
    chk("sh_wdata", s_wd, 32'hABCD_ABCD);
    chk("sh_we", 32'(s_we), 32'd1);
    chk("sh_addr", s_addr, 32'h80);
    chk("sh_result", s_res, 32'h0);
    acc(4'd8, 32'h0000_0201, 32'h0000_0012, 32'h0, 0);
    chk("sb_be", 32'(s_be), 32'h2);
    chk("sb_wdata", s_wd, 32'h1212_1212);

    // Misaligned load: AdEL, no bus activity
    @(negedge clk);
    op = 4'd1; alu = 32'h0000_0101;
    #1;
    chk("lw_mis_exc", 32'(exp_out), 32'd4);
    chk("lw_mis_stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    chk("lw_mis_req", 32'(b_req), 32'd0);
    op = 4'd2; alu = 32'h0000_0101;
    #1;
    chk("lh_mis_exc", 32'(exp_out), 32'd4);
    @(negedge clk);
    op = 4'd7; alu = 32'h0000_0203;
    #1;
    chk("sh_mis_exc", 32'(exp_out), 32'd5);
    chk("sh_mis_req", 32'(b_req), 32'd0);

    // Upstream exception passes through, no access
    @(negedge clk);
    op = 4'd1; alu = 32'h0000_0100; expm = 5'd10;
    #1;
    chk("exp_pass", 32'(exp_out), 32'd10);
    chk("exp_pass_stall", 32'(stall), 32'd0);

    // clr in IDLE suppresses access and exception
    @(negedge clk);
    expm = 5'd9; clr = 1'b1;
    #1;
    chk("clr_idle_exc", 32'(exp_out), 32'd0);
    chk("clr_idle_stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    chk("clr_idle_req", 32'(b_req), 32'd0);
    op = 4'd0; expm = 5'd0; clr = 1'b0;

    // bus_ack outside REQ is ignored
    @(negedge clk);
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    #1;
    chk("stray_ack_stall", 32'(stall), 32'd0);
    @(negedge clk);
    ack = 1'b0; rdata = 32'h0;
    #1;
    chk("stray_ack_real", real_out, 32'd0);
    chk("stray_ack_req", 32'(b_req), 32'd0);

    // clr in first REQ cycle, ack three cycles later: no DONE
    @(negedge clk);
    op = 4'd1; alu = 32'h0000_0100;
    #1;
    chk("kill_idle_stall", 32'(stall), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      clr   = (c == 0);
      ack   = (c == 3);
      rdata = (c == 3) ? 32'h1234_5678 : 32'h0;
      #1;
      chk("kill_req_stall", 32'(stall), 32'd1);
      chk("kill_req_busreq", 32'(b_req), 32'd1);
    end
    @(negedge clk);
    clr = 1'b0; ack = 1'b0; op = 4'd0; rdata = 32'h0;
    #1;
    chk("kill_after_stall", 32'(stall), 32'd0);
    chk("kill_after_real", real_out, 32'd0);
    chk("kill_after_exc", 32'(exp_out), 32'd0);
    chk("kill_after_req", 32'(b_req), 32'd0);

    // Timeout on the TIMEOUT=4 instance
    @(negedge clk);
    to_op = 4'd1; alu = 32'h0000_0100;
    #1;
    chk("to_idle_stall", 32'(to_stall), 32'd1);
    rq_n = 0;
    done_seen = 1'b0;
    s_exc = 5'd0;
    for (int c = 0; c < 12 && !done_seen; c++) begin
      @(negedge clk);
      #1;
      rq_n = rq_n + int'(to_req);
      if (!to_stall) begin
        done_seen = 1'b1;
        s_exc = to_exp;
        s_res = to_real;
      end
    end
    chk("to_done_seen", 32'(done_seen), 32'd1);
    chk("to_req_cycles", 32'(rq_n), 32'd4);
    chk("to_exc", 32'(s_exc), 32'd7);
    chk("to_real", s_res, 32'd0);
    @(negedge clk);
    to_op = 4'd0;
    #1;
    chk("to_idle_exc", 32'(to_exp), 32'd0);
    chk("to_idle_req", 32'(to_req), 32'd0);

    // Reset mid-REQ, then a clean SW
    @(negedge clk);
    op = 4'd1; alu = 32'h0000_0100;
    @(negedge clk);
    #1;
    chk("mid_rst_req_before", 32'(b_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(b_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_be", 32'(b_be), 32'd0);
    @(negedge clk);
    op = 4'd0; alu = 32'h0; reset = 1'b1;
    #1;
    chk("post_rst_real", real_out, 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    acc(4'd6, 32'h0000_0300, 32'h1122_3344, 32'h0, 0);
    chk("sw_stall_cycles", 32'(st_n), 32'd2);
    chk("sw_be", 32'(s_be), 32'hF);
    chk("sw_we", 32'(s_we), 32'd1);
    chk("sw_addr", s_addr, 32'hC0);
    chk("sw_wdata", s_wd, 32'h1122_3344);
    chk("sw_exc", 32'(s_exc), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
